// File: rtl/rca_pipe_pkg.sv
// Shared defaults, flag bundle and helpers for the pipelined ripple-carry adder.
package rca_pipe_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_SEG   = 4;

  typedef struct packed {
    logic cout;
    logic ovf;
    logic zero;
  } flags_t;

  // A legal split has a positive segment width dividing the operand width exactly.
  function automatic bit split_ok(input int width, input int seg);
    return (seg > 0) && (width >= seg) && ((width % seg) == 0);
  endfunction

  // Single full-adder cell, returned as {carry, sum}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
    return {(x & y) | (c & (x ^ y)), x ^ y ^ c};
  endfunction

endpackage

// File: rtl/rca_seg.sv
// Combinational SEG-bit ripple-carry adder built from full-adder cells; also
// exposes the carry into the MSB so the last stage can derive signed overflow.
module rca_seg
  import rca_pipe_pkg::*;
#(
  parameter int SEG = DEF_SEG
) (
  input  logic [SEG-1:0] a_i,
  input  logic [SEG-1:0] b_i,
  input  logic           cin_i,
  output logic [SEG-1:0] sum_o,
  output logic           cout_o,
  output logic           c_msb_o
);

  logic       carry;
  logic [1:0] fa;

  // NOTE: combinational logic uses blocking '=' so the ripple reads the carry
  // just produced, and every output gets a default first so no latch is inferred.
  always_comb begin
    carry   = cin_i;
    fa      = '0;
    sum_o   = '0;
    c_msb_o = 1'b0;
    for (int i = 0; i < SEG; i++) begin
      c_msb_o  = carry;
      fa       = full_add(a_i[i], b_i[i], carry);
      sum_o[i] = fa[0];
      carry    = fa[1];
    end
    cout_o = carry;
  end

endmodule

// File: rtl/rca_pipe.sv
// Pipelined ripple-carry adder/subtractor: one SEG-bit segment per stage, carry
// registered between stages, operand skew in front and result deskew behind.
module rca_pipe
  import rca_pipe_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEG   = DEF_SEG
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int D = WIDTH / SEG;

  if (!split_ok(WIDTH, SEG)) begin : g_bad_split
    $error("rca_pipe: WIDTH must be a non-zero multiple of SEG");
  end

  logic             en;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic [D-1:0]     vld_q;
  logic [D-1:0]     carry_q;
  logic [D-1:0]     seg_cout;
  logic             last_c_msb;
  logic [WIDTH-1:0] aligned_sum;
  logic             out_valid_q;
  logic [WIDTH-1:0] sum_q;
  flags_t           flags_q;
  flags_t           flags_d;

  // One global enable: the whole pipe advances only when the output slot frees up.
  assign en       = out_ready || !out_valid_q;
  assign in_ready = en;

  // Subtraction is a + ~b + ~cin, so cin acts as a borrow-in.
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = cin ^ sub;

  // NOTE: datapath registers carry no reset; only valid bits and the output
  // register are reset, since bubbles are tracked by the valid chain alone.
  always_ff @(posedge clk) begin
    if (en) begin
      carry_q[0] <= cin_eff;
      for (int k = 1; k < D; k++) begin
        carry_q[k] <= seg_cout[k-1];
      end
    end
  end

  for (genvar k = 0; k < D; k++) begin : g_stage
    logic [SEG-1:0] a_skew_q [k+1];
    logic [SEG-1:0] b_skew_q [k+1];
    logic [SEG-1:0] seg_sum;
    logic           seg_c_msb;

    always_ff @(posedge clk) begin
      if (en) begin
        a_skew_q[0] <= a[k*SEG +: SEG];
        b_skew_q[0] <= b_eff[k*SEG +: SEG];
        for (int j = 1; j <= k; j++) begin
          a_skew_q[j] <= a_skew_q[j-1];
          b_skew_q[j] <= b_skew_q[j-1];
        end
      end
    end

    rca_seg #(
      .SEG (SEG)
    ) u_seg (
      .a_i     (a_skew_q[k]),
      .b_i     (b_skew_q[k]),
      .cin_i   (carry_q[k]),
      .sum_o   (seg_sum),
      .cout_o  (seg_cout[k]),
      .c_msb_o (seg_c_msb)
    );

    if (k == D-1) begin : g_last
      assign aligned_sum[k*SEG +: SEG] = seg_sum;
      assign last_c_msb                = seg_c_msb;
    end else begin : g_mid
      // Earlier segments wait here until the top segment catches up.
      logic [SEG-1:0] dsk_q [D-1-k];
      logic           unused_c_msb;

      assign unused_c_msb = seg_c_msb;

      always_ff @(posedge clk) begin
        if (en) begin
          dsk_q[0] <= seg_sum;
          for (int j = 1; j < D-1-k; j++) begin
            dsk_q[j] <= dsk_q[j-1];
          end
        end
      end

      assign aligned_sum[k*SEG +: SEG] = dsk_q[D-2-k];
    end
  end

  always_comb begin
    flags_d      = '0;
    flags_d.cout = seg_cout[D-1];
    flags_d.ovf  = last_c_msb ^ seg_cout[D-1];
    flags_d.zero = (aligned_sum == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q       <= '0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      flags_q     <= '0;
    end else if (en) begin
      vld_q[0] <= in_valid;
      for (int k = 1; k < D; k++) begin
        vld_q[k] <= vld_q[k-1];
      end
      out_valid_q <= vld_q[D-1];
      if (vld_q[D-1]) begin
        sum_q   <= aligned_sum;
        flags_q <= flags_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = flags_q.cout;
  assign ovf       = flags_q.ovf;
  assign zero      = flags_q.zero;

endmodule
